// File: rtl/phase_sampler.sv
// Phase sampler for a coupled spin-oscillator array: enables the array, lets it settle,
// then votes each oscillator's agreement with oscillator 0 over a window into a spin bit.
module phase_sampler #(
  parameter int N             = 3,
  parameter int SETTLE_CYCLES = 1024,
  parameter int SAMPLE_CYCLES = 256
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic [N-1:0] osc_in,
  output logic         core_en,
  output logic         busy,
  output logic         valid,
  input  logic         ack,
  output logic [N-1:0] spins
);

  localparam int MAXC = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int AW   = $clog2(SAMPLE_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_MEASURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // Strict majority: a tie over the window resolves to 0.
  function automatic logic majority(input logic [AW-1:0] cnt);
    return {cnt, 1'b0} > (AW+1)'(SAMPLE_CYCLES);
  endfunction

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_go;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_sync1;
  logic [N-1:0]   r_sync2;
  logic [N-1:0]   w_osc_s;
  logic [AW-1:0]  r_agree     [N];
  logic [AW-1:0]  w_agree_nxt [N];
  logic           w_settle_end;
  logic           w_meas_end;
  logic           w_state_chg;
  logic           r_core_en;
  logic           r_busy;
  logic           r_valid;
  logic [N-1:0]   r_spins;

  // Stage: two-flop synchronizer for the asynchronous oscillator outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= osc_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_osc_s = r_sync2;

  // start is captured once in IDLE; the FSM acts on the captured copy, which places
  // valid SETTLE_CYCLES+SAMPLE_CYCLES+1 edges after the sampling edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_go <= 1'b0;
    end else begin
      r_go <= (r_state == S_IDLE) && start;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_settle_end = 1'b0;
    w_meas_end   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_go) w_state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (r_cnt == CW'(SETTLE_CYCLES - 1)) begin
          w_state_nxt  = S_MEASURE;
          w_settle_end = 1'b1;
        end
      end
      S_MEASURE: begin
        if (r_cnt == CW'(SAMPLE_CYCLES - 1)) begin
          w_state_nxt = S_DONE;
          w_meas_end  = 1'b1;
        end
      end
      S_DONE: begin
        if (ack) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_state_chg = (w_state_nxt != r_state);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (w_state_chg) begin
      r_cnt <= '0;
    end else if (r_state == S_SETTLE || r_state == S_MEASURE) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Stage: agreement counting against the phase reference (oscillator 0)
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_agree_nxt[i] = r_agree[i] + AW'(w_osc_s[i] == w_osc_s[0]);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N; i++) r_agree[i] <= '0;
    end else if (w_settle_end) begin
      for (int i = 0; i < N; i++) r_agree[i] <= '0;
    end else if (r_state == S_MEASURE) begin
      for (int i = 0; i < N; i++) r_agree[i] <= w_agree_nxt[i];
    end
  end

  // Stage: result and registered status outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_spins <= '0;
    end else if (w_meas_end) begin
      for (int i = 0; i < N; i++) r_spins[i] <= majority(w_agree_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_core_en <= 1'b0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_core_en <= (w_state_nxt == S_SETTLE) || (w_state_nxt == S_MEASURE);
      r_busy    <= (w_state_nxt == S_SETTLE) || (w_state_nxt == S_MEASURE);
      r_valid   <= (w_state_nxt == S_DONE);
    end
  end

  assign core_en = r_core_en;
  assign busy    = r_busy;
  assign valid   = r_valid;
  assign spins   = r_spins;

endmodule
